control_ascensor: RTL and testbench
===================================

# control_ascensor

Sequencing controller for the four-floor elevator car. It latches floor requests, chooses the travel direction with a collective (sweep) policy, and drives the motor floor by floor. It parks the car at served floors and hands off to the door controller through the `trabajando` handshake. It produces the `estado` word and the latched request vector that the door controller consumes.

## Interface
- `T_VIAJE`, 8: clock cycles of motor travel between adjacent floors (≥2).
- `T_ABRIR`, 16: cycles to wait for the door controller to assert `trabajando` before forcing service complete (≥2).

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `pisos`  in  10  request pulses:
  - bit 0: hall up, floor 0.
  - bits 1/2: hall up/down, floor 1.
  - bits 3/4: hall up/down, floor 2.
  - bit 5: hall down, floor 3.
  - bits 6..9: cabin buttons, floors 0..3.
- `trabajando`  in  1  door controller busy (doors not closed, or opening).
- `pendientes`  out  10  latched requests, same bit map as `pisos`; drives the door controller's `pisos`.
- `estado`  out  4  car state:
  - `estado[3]`: 1 = moving.
  - `estado[2]`: direction, 0 = up, 1 = down.
  - Floor number = {`estado[0]`, `estado[1]`}; `estado[0]` is the MSB.
- `motor`  out  2  01 = up, 10 = down, 00 = stop; 11 never driven.

## Operation
- **Request latch**
  - Each clock: `pendientes <= (pendientes & ~clr) | pisos`. Set wins over clear in the same cycle.
- **Definitions**, for floor f and direction d:
  - *ahead*: any pending bit belonging to a floor beyond f in direction d.
  - *behind*: any pending bit belonging to a floor beyond f in the opposite direction.
  - *servir*: any of:
    - cabin bit of f;
    - hall bit of f in direction d;
    - hall bit of f opposite to d, when not ahead.
    - Floors 0 and 3 have a single hall bit, which counts in either direction.
- **FSM states**: REPOSO, ABRIENDO, SERVICIO, MOVIENDO.
- **REPOSO** (`estado[3]=0`, `motor=00`). Evaluated only when `trabajando=0`; otherwise stay.
  - If servir: go to ABRIENDO. If the served hall bit is opposite to d, flip `estado[2]` on the same edge so the door controller's direction-qualified check matches.
  - Else if ahead: go to MOVIENDO, load travel counter with `T_VIAJE-1`, set `motor` per d.
  - Else if behind: flip d and stay in REPOSO (one cycle).
  - Else stay.
- **ABRIENDO**: waits for `trabajando=1`, with a wait counter loaded with `T_ABRIR-1` on entry.
  - On the first cycle `trabajando=1`: clear the served bits (cabin bit of f plus the hall bit matching d; the single hall bit at floors 0/3), then go to SERVICIO.
  - If the wait counter expires first: clear the same bits and go to REPOSO.
- **SERVICIO**: stay while `trabajando=1`; go to REPOSO on the first cycle `trabajando=0`. Requests for f arriving meanwhile stay latched and are re-served from REPOSO.
- **MOVIENDO** (`estado[3]=1`): travel counter decrements each cycle. At 0:
  - floor ← f±1;
  - if servir at the new floor or not ahead: `motor=00`, go to REPOSO;
  - else reload the counter and continue.
- **Boundaries**
  - At floor 3 with d=up and not ahead, REPOSO flips d (per the rules above).
  - The floor never steps outside 0..3; MOVIENDO is entered only when ahead is true.
- **Reset** (async, any state, including mid-travel):
  - FSM=REPOSO, floor=0, d=up;
  - `estado=0000`, `motor=00`, `pendientes=0`;
  - counters=0.

## Timing
- `pendientes` is registered: a pulse on `pisos` at edge k is visible after edge k.
- REPOSO decides from registered `pendientes`. A request latched at edge k can start ABRIENDO or MOVIENDO at edge k+1.
- `motor` and `estado[3]` change on the same edge as the state transition.
- Floor-to-floor time is exactly `T_VIAJE` cycles from motor start or from the previous floor step.
- Clearing of served bits is visible the cycle after `trabajando` is first sampled high.
- Worst case, no doors involved: ABRIENDO timeout after `T_ABRIR` cycles.

## Test plan
- Reset, 1-cycle pulse `pisos[9]` → `pendientes[9]=1` next cycle; next edge `motor=01`, `estado=1000`. Floor steps at +8/+16/+24 cycles; at floor 3 `motor=00`, then ABRIENDO.
- Floor 0 idle, pulse `pisos[6]`, model `trabajando` high 5 cycles → bit 6 clears the cycle after `trabajando` rises; REPOSO after it falls; `motor` stays 00.
- Car leaving floor 0 for cabin 3; pulse `pisos[2]` (floor 1 down) → no stop at floor 1 going up. After serving floor 3, d flips, car stops at floor 1 with `estado[2]=1` and clears bit 2.
- Pending `pisos[8]`, `trabajando` tied 0 → ABRIENDO times out after 16 cycles, bit 8 cleared, REPOSO.
- `rst_n` low mid-MOVIENDO (between floors 1 and 2) → same-cycle `motor=00`, `estado=0000`, `pendientes=0`.
- Pulse `pisos[6]` on the exact clearing edge of bit 6 → bit 6 remains 1, and floor 0 is served again.

Source files
------------

// File: rtl/control_ascensor_if.sv
// Signal bundle between the elevator sequencing controller and its environment
// (call buttons, door controller, motor driver).
interface control_ascensor_if;
  logic [9:0] pisos;
  logic       trabajando;
  logic [9:0] pendientes;
  logic [3:0] estado;
  logic [1:0] motor;

  modport master (
    input  pisos,
    input  trabajando,
    output pendientes,
    output estado,
    output motor
  );

  modport slave (
    output pisos,
    output trabajando,
    input  pendientes,
    input  estado,
    input  motor
  );
endinterface

// File: rtl/control_ascensor.sv
// Four-floor elevator sequencer: latches requests, sweeps up/down collectively,
// steps the motor floor by floor and hands each stop to the door controller.
module control_ascensor #(
  parameter int unsigned T_VIAJE = 8,
  parameter int unsigned T_ABRIR = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  control_ascensor_if.master        bus
);

  localparam int unsigned VW = $clog2(T_VIAJE);
  localparam int unsigned AW = $clog2(T_ABRIR);
  localparam logic [VW-1:0] VIAJE_INI = VW'(T_VIAJE - 1);
  localparam logic [AW-1:0] ABRIR_INI = AW'(T_ABRIR - 1);

  typedef enum logic [1:0] {StReposo, StAbriendo, StServicio, StMoviendo} estado_e;

  // Floors 0 and 3 own a single hall bit that answers for both directions.
  function automatic logic [9:0] hall_mask(input logic [1:0] f, input logic d);
    logic [9:0] m;
    m = '0;
    unique case (f)
      2'd0: m[0] = 1'b1;
      2'd1: if (d) m[2] = 1'b1; else m[1] = 1'b1;
      2'd2: if (d) m[4] = 1'b1; else m[3] = 1'b1;
      2'd3: m[5] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [9:0] cab_mask(input logic [1:0] f);
    logic [9:0] m;
    m = '0;
    m[6 + int'(f)] = 1'b1;
    return m;
  endfunction

  function automatic logic [3:0] floor_any(input logic [9:0] p);
    return {p[5] | p[9], p[3] | p[4] | p[8], p[1] | p[2] | p[7], p[0] | p[6]};
  endfunction

  function automatic logic ahead_of(input logic [9:0] p, input logic [1:0] f, input logic d);
    logic [3:0] a;
    logic       r;
    a = floor_any(p);
    r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (d ? (i < int'(f)) : (i > int'(f))) r = r | a[i];
    end
    return r;
  endfunction

  function automatic logic servir_en(input logic [9:0] p, input logic [1:0] f, input logic d);
    return (|(p & cab_mask(f))) | (|(p & hall_mask(f, d))) |
           ((|(p & hall_mask(f, ~d))) & ~ahead_of(p, f, d));
  endfunction

  estado_e       r_state, w_state_nxt;
  logic [1:0]    r_piso, w_piso_nxt, w_piso_sig;
  logic          r_dir, w_dir_nxt;
  logic [9:0]    r_pend, w_pend_nxt, w_clr;
  logic [VW-1:0] r_cnt_v, w_cnt_v_nxt;
  logic [AW-1:0] r_cnt_a, w_cnt_a_nxt;

  logic w_ahead, w_behind, w_servir, w_flip, w_ahead_sig, w_servir_sig;

  assign w_ahead      = ahead_of(r_pend, r_piso, r_dir);
  assign w_behind     = ahead_of(r_pend, r_piso, ~r_dir);
  assign w_servir     = servir_en(r_pend, r_piso, r_dir);
  // Only the opposite-direction hall call is being answered: turn around so the
  // door controller's direction-qualified check and the clear both match it.
  assign w_flip       = ~(|(r_pend & hall_mask(r_piso, r_dir))) &
                        (|(r_pend & hall_mask(r_piso, ~r_dir))) & ~w_ahead;
  assign w_piso_sig   = r_dir ? (r_piso - 2'd1) : (r_piso + 2'd1);
  assign w_ahead_sig  = ahead_of(r_pend, w_piso_sig, r_dir);
  assign w_servir_sig = servir_en(r_pend, w_piso_sig, r_dir);

  always_comb begin
    w_state_nxt = r_state;
    w_piso_nxt  = r_piso;
    w_dir_nxt   = r_dir;
    w_cnt_v_nxt = r_cnt_v;
    w_cnt_a_nxt = r_cnt_a;
    w_clr       = '0;
    unique case (r_state)
      StReposo: begin
        if (!bus.trabajando) begin
          if (w_servir) begin
            w_state_nxt = StAbriendo;
            w_cnt_a_nxt = ABRIR_INI;
            if (w_flip) w_dir_nxt = ~r_dir;
          end else if (w_ahead) begin
            w_state_nxt = StMoviendo;
            w_cnt_v_nxt = VIAJE_INI;
          end else if (w_behind) begin
            w_dir_nxt = ~r_dir;
          end
        end
      end
      StAbriendo: begin
        if (bus.trabajando || (r_cnt_a == '0)) begin
          w_clr       = cab_mask(r_piso) | hall_mask(r_piso, r_dir);
          w_state_nxt = bus.trabajando ? StServicio : StReposo;
        end else begin
          w_cnt_a_nxt = r_cnt_a - AW'(1);
        end
      end
      StServicio: begin
        if (!bus.trabajando) w_state_nxt = StReposo;
      end
      StMoviendo: begin
        if (r_cnt_v == '0) begin
          w_piso_nxt = w_piso_sig;
          if (w_servir_sig || !w_ahead_sig) begin
            w_state_nxt = StReposo;
          end else begin
            w_cnt_v_nxt = VIAJE_INI;
          end
        end else begin
          w_cnt_v_nxt = r_cnt_v - VW'(1);
        end
      end
      default: w_state_nxt = StReposo;
    endcase
  end

  // New requests win over the clear of the bits being served.
  assign w_pend_nxt = (r_pend & ~w_clr) | bus.pisos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StReposo;
      r_piso  <= '0;
      r_dir   <= 1'b0;
      r_pend  <= '0;
      r_cnt_v <= '0;
      r_cnt_a <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_piso  <= w_piso_nxt;
      r_dir   <= w_dir_nxt;
      r_pend  <= w_pend_nxt;
      r_cnt_v <= w_cnt_v_nxt;
      r_cnt_a <= w_cnt_a_nxt;
    end
  end

  assign bus.pendientes = r_pend;
  assign bus.estado     = {r_state == StMoviendo, r_dir, r_piso[0], r_piso[1]};
  assign bus.motor      = (r_state != StMoviendo) ? 2'b00 : (r_dir ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_control_ascensor.sv
// Directed bench for control_ascensor: travel timing, door handshake, timeout,
// sweep reversal, async reset and set-over-clear.
module tb_control_ascensor;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  control_ascensor_if bus ();

  control_ascensor #(
    .T_VIAJE(8),
    .T_ABRIR(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int b);
    bus.pisos = 10'd1 << b;
    tick(1);
    bus.pisos = '0;
  endtask

  task automatic do_reset(input string tag);
    bus.pisos      = '0;
    bus.trabajando = 1'b0;
    rst_n          = 1'b0;
    #2;
    check_eq({tag, "_pend"}, 32'(bus.pendientes), 32'h0);
    check_eq({tag, "_estado"}, 32'(bus.estado), 32'h0);
    check_eq({tag, "_motor"}, 32'(bus.motor), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.pisos      = '0;
    bus.trabajando = 1'b0;
    #12;

    // Cabin call to floor 3 from floor 0
    do_reset("rst1");
    pulse(9);
    check_eq("t1_latch", 32'(bus.pendientes), 32'h200);
    check_eq("t1_motor_idle", 32'(bus.motor), 32'h0);
    tick(1);
    check_eq("t1_motor_up", 32'(bus.motor), 32'h1);
    check_eq("t1_estado_mov", 32'(bus.estado), 32'b1000);
    tick(7);
    check_eq("t1_still_f0", 32'(bus.estado), 32'b1000);
    tick(1);
    check_eq("t1_f1", 32'(bus.estado), 32'b1010);
    tick(8);
    check_eq("t1_f2", 32'(bus.estado), 32'b1001);
    tick(8);
    check_eq("t1_f3_stop", 32'(bus.estado), 32'b0011);
    check_eq("t1_motor_stop", 32'(bus.motor), 32'h0);
    tick(1);
    check_eq("t1_pend_opening", 32'(bus.pendientes), 32'h200);
    bus.trabajando = 1'b1;
    tick(1);
    check_eq("t1_cleared", 32'(bus.pendientes), 32'h0);
    bus.trabajando = 1'b0;
    tick(3);
    check_eq("t1_idle_f3", 32'(bus.estado), 32'b0011);

    // Cabin call at current floor, doors busy 5 cycles
    do_reset("rst2");
    pulse(6);
    check_eq("t2_latch", 32'(bus.pendientes), 32'h40);
    tick(1);
    bus.trabajando = 1'b1;
    tick(1);
    check_eq("t2_cleared", 32'(bus.pendientes), 32'h0);
    check_eq("t2_motor", 32'(bus.motor), 32'h0);
    tick(4);
    bus.trabajando = 1'b0;
    tick(1);
    check_eq("t2_estado", 32'(bus.estado), 32'h0);
    check_eq("t2_motor_end", 32'(bus.motor), 32'h0);

    // Request on the clearing edge survives and is served again
    tick(1);
    pulse(6);
    tick(1);
    bus.trabajando = 1'b1;
    bus.pisos      = 10'h40;
    tick(1);
    check_eq("t6_set_wins", 32'(bus.pendientes), 32'h40);
    bus.pisos      = '0;
    bus.trabajando = 1'b0;
    tick(2);
    check_eq("t6_pending", 32'(bus.pendientes), 32'h40);
    bus.trabajando = 1'b1;
    tick(1);
    check_eq("t6_reserved", 32'(bus.pendientes), 32'h0);
    bus.trabajando = 1'b0;
    tick(1);

    // Sweep: hall down at floor 1 is skipped going up, served coming down
    do_reset("rst3");
    pulse(9);
    tick(1);
    check_eq("t3_motor_up", 32'(bus.motor), 32'h1);
    pulse(2);
    check_eq("t3_latch", 32'(bus.pendientes), 32'h204);
    tick(7);
    check_eq("t3_pass_f1", 32'(bus.estado), 32'b1010);
    check_eq("t3_pass_motor", 32'(bus.motor), 32'h1);
    tick(8);
    check_eq("t3_f2", 32'(bus.estado), 32'b1001);
    tick(8);
    check_eq("t3_f3_stop", 32'(bus.estado), 32'b0011);
    check_eq("t3_f3_pend", 32'(bus.pendientes), 32'h204);
    tick(1);
    bus.trabajando = 1'b1;
    tick(1);
    check_eq("t3_clear9", 32'(bus.pendientes), 32'h004);
    bus.trabajando = 1'b0;
    tick(2);
    check_eq("t3_flip", 32'(bus.estado), 32'b0111);
    tick(1);
    check_eq("t3_down_estado", 32'(bus.estado), 32'b1111);
    check_eq("t3_down_motor", 32'(bus.motor), 32'h2);
    tick(8);
    check_eq("t3_down_f2", 32'(bus.estado), 32'b1101);
    tick(8);
    check_eq("t3_stop_f1", 32'(bus.estado), 32'b0110);
    check_eq("t3_stop_motor", 32'(bus.motor), 32'h0);
    tick(1);
    bus.trabajando = 1'b1;
    tick(1);
    check_eq("t3_clear2", 32'(bus.pendientes), 32'h0);
    bus.trabajando = 1'b0;
    tick(1);

    // Door controller never answers: ABRIENDO times out
    do_reset("rst4");
    pulse(8);
    tick(1);
    check_eq("t4_motor_up", 32'(bus.motor), 32'h1);
    tick(16);
    check_eq("t4_f2_stop", 32'(bus.estado), 32'b0001);
    tick(1);
    tick(15);
    check_eq("t4_before_to", 32'(bus.pendientes), 32'h100);
    tick(1);
    check_eq("t4_timeout", 32'(bus.pendientes), 32'h0);
    tick(2);
    check_eq("t4_idle_motor", 32'(bus.motor), 32'h0);
    check_eq("t4_idle_estado", 32'(bus.estado), 32'b0001);

    // Asynchronous reset between floors 1 and 2
    do_reset("rst5");
    pulse(9);
    tick(10);
    check_eq("t5_mid_travel", 32'(bus.estado), 32'b1010);
    check_eq("t5_mid_pend", 32'(bus.pendientes), 32'h200);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_motor", 32'(bus.motor), 32'h0);
    check_eq("t5_async_estado", 32'(bus.estado), 32'h0);
    check_eq("t5_async_pend", 32'(bus.pendientes), 32'h0);
    do_reset("rst6");
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
